// File: rtl/mul_sched.sv
// mul_sched: arbitrates two requesters onto a shared shift-add multiplier.
// One unsigned WIDTH x WIDTH multiply runs over exactly WIDTH steps and the
// 2*WIDTH product is returned tagged with the requester that owns it.
module mul_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_id_q, last_id_d;
  logic               owner_q, owner_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [2*WIDTH-1:0] acc_next;
  logic               sel;

  // One shift-add step and the round-robin owner choice.
  always_comb begin
    acc_next = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    if (req0 && req1) sel = ~last_id_q;
    else              sel = req1;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    last_id_d = last_id_q;
    owner_d   = owner_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d   = sel;
          last_id_d = sel;
          mcand_d   = {{WIDTH{1'b0}}, (sel ? a1 : a0)};
          mplr_d    = sel ? b1 : b0;
          acc_d     = '0;
          cnt_d     = '0;
          gnt0_d    = ~sel;
          gnt1_d    = sel;
          state_d   = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          product_d = acc_next;
          done_d    = 1'b1;
          done_id_d = owner_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      last_id_q <= 1'b1;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      last_id_q <= last_id_d;
      owner_q   <= owner_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign product = product_q;

endmodule
